// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with synchronous load, soft clear,
// terminal-count flag and a registered rollover pulse for cascading stages.
module counter_updown_mod #(
  parameter int BITS     = 4,
  parameter int MOD      = 2**BITS,
  parameter int INIT     = 0,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            r,
  input  logic            en,
  input  logic            up,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] state,
  output logic            tc,
  output logic            rollover
);

  localparam logic [BITS-1:0] MAX_C  = BITS'(MOD - 1);
  localparam logic [BITS-1:0] INIT_C = BITS'(INIT);
  localparam logic [BITS-1:0] ZERO_C = BITS'(0);
  localparam logic [BITS-1:0] ONE_C  = BITS'(1);
  localparam logic            SAT_C  = (SATURATE != 0);

  logic [BITS-1:0] state_q, state_d;
  logic            roll_q, roll_d;

  // Next-state selection: clr > load > en; reset is applied in the register block.
  always_comb begin
    state_d = state_q;
    roll_d  = 1'b0;
    if (clr) begin
      state_d = ZERO_C;
    end else if (load) begin
      state_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (up) begin
        // Compare before incrementing so the sum never leaves BITS; out-of-range acts as the top.
        if (state_q >= MAX_C) begin
          if (SAT_C) begin
            state_d = MAX_C;
          end else begin
            state_d = ZERO_C;
            roll_d  = 1'b1;
          end
        end else begin
          state_d = state_q + ONE_C;
        end
      end else begin
        if (state_q == ZERO_C) begin
          if (SAT_C) begin
            state_d = ZERO_C;
          end else begin
            state_d = MAX_C;
            roll_d  = 1'b1;
          end
        end else if (state_q > MAX_C) begin
          state_d = MAX_C;
        end else begin
          state_d = state_q - ONE_C;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Count and rollover registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= INIT_C;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      roll_q  <= roll_d;
    end
  end

  assign state    = state_q;
  assign rollover = roll_q;
  assign tc       = (up && (state_q == MAX_C)) || (!up && (state_q == ZERO_C));

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed plus random bench for counter_updown_mod against an integer reference model.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       r = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0, casc_en = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] st [4];
  logic       tcv [4];
  logic       ro [4];
  logic [3:0] lo_st, hi_st;
  logic       lo_tc, hi_tc, lo_ro, hi_ro;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one entry per single-stage instance plus a 0..99 cascade count.
  int m_mod  [4] = '{16, 10, 10, 10};
  int m_sat  [4] = '{0, 0, 1, 0};
  int m_init [4] = '{0, 0, 0, 3};
  int m_st   [4];
  int m_ro   [4];
  int c_cnt;
  int c_ro;

  always #5 clk = ~clk;

  counter_updown_mod #(.BITS(4), .MOD(16), .INIT(0), .SATURATE(0)) u16 (
    .clk(clk), .r(r), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .state(st[0]), .tc(tcv[0]), .rollover(ro[0]));
  counter_updown_mod #(.BITS(4), .MOD(10), .INIT(0), .SATURATE(0)) u10 (
    .clk(clk), .r(r), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .state(st[1]), .tc(tcv[1]), .rollover(ro[1]));
  counter_updown_mod #(.BITS(4), .MOD(10), .INIT(0), .SATURATE(1)) s10 (
    .clk(clk), .r(r), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .state(st[2]), .tc(tcv[2]), .rollover(ro[2]));
  counter_updown_mod #(.BITS(4), .MOD(10), .INIT(3), .SATURATE(0)) i3 (
    .clk(clk), .r(r), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .state(st[3]), .tc(tcv[3]), .rollover(ro[3]));
  counter_updown_mod #(.BITS(4), .MOD(10), .INIT(0), .SATURATE(0)) c_lo (
    .clk(clk), .r(r), .en(casc_en), .up(1'b1), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .state(lo_st), .tc(lo_tc), .rollover(lo_ro));
  counter_updown_mod #(.BITS(4), .MOD(10), .INIT(0), .SATURATE(0)) c_hi (
    .clk(clk), .r(r), .en(casc_en && lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .state(hi_st), .tc(hi_tc), .rollover(hi_ro));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_st[i] = m_init[i]; m_ro[i] = 0;
      end else if (clr) begin
        m_st[i] = 0; m_ro[i] = 0;
      end else if (load) begin
        m_st[i] = (int'(load_val) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(load_val);
        m_ro[i] = 0;
      end else if (en) begin
        m_ro[i] = 0;
        if (up) begin
          if (m_st[i] < m_mod[i] - 1) m_st[i] = m_st[i] + 1;
          else if (m_sat[i] == 0) begin m_st[i] = 0; m_ro[i] = 1; end
        end else begin
          if (m_st[i] > 0) m_st[i] = m_st[i] - 1;
          else if (m_sat[i] == 0) begin m_st[i] = m_mod[i] - 1; m_ro[i] = 1; end
        end
      end else begin
        m_ro[i] = 0;
      end
    end
    if (r) begin
      c_cnt = 0; c_ro = 0;
    end else if (casc_en) begin
      c_ro  = (c_cnt == 99) ? 1 : 0;
      c_cnt = (c_cnt + 1) % 100;
    end else begin
      c_ro = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("state[%0d]", i), 32'(st[i]), 32'(m_st[i]));
      check($sformatf("rollover[%0d]", i), 32'(ro[i]), 32'(m_ro[i]));
      check($sformatf("tc[%0d]", i), 32'(tcv[i]),
            32'((up && m_st[i] == m_mod[i] - 1) || (!up && m_st[i] == 0)));
    end
    check("cascade", 32'(int'(hi_st) * 10 + int'(lo_st)), 32'(c_cnt));
    check("cascade_roll", 32'(hi_ro), 32'(c_ro));
  endtask

  int rolls;

  initial begin
    for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_ro[i] = 0; end
    c_cnt = 0; c_ro = 0;

    // Reset for two cycles
    r = 1'b1; step(); step();
    check("reset_u16", 32'(st[0]), 32'd0);
    check("reset_init3", 32'(st[3]), 32'd3);
    r = 1'b0;

    // Test 1: count up 17 times on MOD=16
    en = 1'b1; up = 1'b1; rolls = 0;
    for (int k = 0; k < 17; k++) begin
      step();
      if (ro[0]) rolls++;
      check("t1_tc_at_15", 32'(tcv[0]), 32'(st[0] == 4'd15));
    end
    check("t1_final", 32'(st[0]), 32'd1);
    check("t1_rollcount", 32'(rolls), 32'd1);

    // Test 2: count down on MOD=10 from reset
    r = 1'b1; en = 1'b0; step(); r = 1'b0;
    check("t2_tc_at0", 32'(tcv[1]), 32'(up ? 1'b0 : 1'b1));
    en = 1'b1; up = 1'b0; step();
    check("t2_wrap9", 32'(st[1]), 32'd9);
    check("t2_roll", 32'(ro[1]), 32'd1);
    step();
    check("t2_eight", 32'(st[1]), 32'd8);

    // Test 3: saturating counter held at both ends
    en = 1'b0; load = 1'b1; load_val = 4'd8; step(); load = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("t3_sat_top", 32'(st[2]), 32'd9);
    check("t3_no_roll", 32'(ro[2]), 32'd0);
    up = 1'b0;
    for (int k = 0; k < 11; k++) step();
    check("t3_sat_bot", 32'(st[2]), 32'd0);

    // Test 4: priority and load clamp
    clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; step();
    check("t4_clr_wins", 32'(st[1]), 32'd0);
    clr = 1'b0; step();
    check("t4_load_wins", 32'(st[1]), 32'd5);
    load_val = 4'd12; step();
    check("t4_clamp", 32'(st[1]), 32'd9);
    check("t4_noclamp16", 32'(st[0]), 32'd12);
    load = 1'b0;

    // Test 5: reset mid-count with INIT=3
    en = 1'b0; r = 1'b1; step(); r = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("t5_seven", 32'(st[3]), 32'd7);
    r = 1'b1; step(); r = 1'b0;
    check("t5_reset", 32'(st[3]), 32'd3);
    check("t5_roll", 32'(ro[3]), 32'd0);
    step(); step();
    check("t5_resume", 32'(st[3]), 32'd5);

    // Test 6: two-stage decimal cascade for 100 cycles
    en = 1'b0; r = 1'b1; step(); r = 1'b0;
    casc_en = 1'b1; rolls = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (hi_ro) rolls++;
    end
    check("t6_wrap", 32'({hi_st, lo_st}), 32'h00);
    check("t6_rollcount", 32'(rolls), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      r        = ($urandom_range(0, 31) == 0);
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      casc_en  = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
